// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter: FSM state encoding,
// BCD digit width and the per-digit roll-over limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] LIMIT_NINE = 4'd9;
    localparam logic [DIGIT_W-1:0] LIMIT_FIVE = 4'd5;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit that counts 0..LIMIT on inc and rolls back to 0,
// with a combinational carry into the next digit of the chain.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] LIMIT = LIMIT_NINE
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry_out
);

    assign carry_out = inc && (digit == LIMIT);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= (digit == LIMIT) ? '0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS.CC BCD stopwatch driven by rising edges of the 100 Hz divider output.
// Optional LAP_HOLD_EN macro adds a lap input that freezes the displayed digits.
//
// state | meaning
// IDLE  | count zero, stopped
// RUN   | counting one centisecond per 100 Hz rising edge
// PAUSE | stopped, count retained until clear
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_MINUTES = 59
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               clk_100hz_in,
    input  logic               start_stop,
    input  logic               clear,
`ifdef LAP_HOLD_EN
    input  logic               lap,
`endif
    output logic [DIGIT_W-1:0] cs_tens,
    output logic [DIGIT_W-1:0] cs_ones,
    output logic [DIGIT_W-1:0] s_tens,
    output logic [DIGIT_W-1:0] s_ones,
    output logic [DIGIT_W-1:0] m_tens,
    output logic [DIGIT_W-1:0] m_ones,
    output logic               running,
    output logic               overflow
);

    localparam logic [DIGIT_W-1:0] MAX_M_TENS = 4'(MAX_MINUTES / 10);
    localparam logic [DIGIT_W-1:0] MAX_M_ONES = 4'(MAX_MINUTES % 10);

    state_t state;
    state_t state_next;
    logic   prev;
    logic   tick;
    logic   count_en;
    logic   clr_count;

    logic [DIGIT_W-1:0] live_cs_ones;
    logic [DIGIT_W-1:0] live_cs_tens;
    logic [DIGIT_W-1:0] live_s_ones;
    logic [DIGIT_W-1:0] live_s_tens;
    logic [DIGIT_W-1:0] live_m_ones;
    logic [DIGIT_W-1:0] live_m_tens;
    logic               carry_cs_ones;
    logic               carry_cs_tens;
    logic               carry_s_ones;
    logic               min_inc;
    logic               at_max;
    logic               wrap;

    assign tick      = clk_100hz_in && !prev;
    assign count_en  = tick && (state == RUN);
    // Clear is ignored in RUN; in IDLE it is a no-op for the digits.
    assign clr_count = clear && (state != RUN);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            prev  <= 1'b0;
            state <= IDLE;
        end else begin
            prev  <= clk_100hz_in;
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!clear && start_stop) state_next = RUN;
            end
            RUN: begin
                if (start_stop) state_next = PAUSE;
            end
            PAUSE: begin
                if (clear)           state_next = IDLE;
                else if (start_stop) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    assign running = (state == RUN);

    bcd_digit_counter #(.LIMIT(LIMIT_NINE)) u_cs_ones (
        .clk_in(clk_in), .rst(rst), .clr(clr_count), .inc(count_en),
        .digit(live_cs_ones), .carry_out(carry_cs_ones)
    );

    bcd_digit_counter #(.LIMIT(LIMIT_NINE)) u_cs_tens (
        .clk_in(clk_in), .rst(rst), .clr(clr_count), .inc(carry_cs_ones),
        .digit(live_cs_tens), .carry_out(carry_cs_tens)
    );

    bcd_digit_counter #(.LIMIT(LIMIT_NINE)) u_s_ones (
        .clk_in(clk_in), .rst(rst), .clr(clr_count), .inc(carry_cs_tens),
        .digit(live_s_ones), .carry_out(carry_s_ones)
    );

    bcd_digit_counter #(.LIMIT(LIMIT_FIVE)) u_s_tens (
        .clk_in(clk_in), .rst(rst), .clr(clr_count), .inc(carry_s_ones),
        .digit(live_s_tens), .carry_out(min_inc)
    );

    // Minutes wrap at MAX_MINUTES rather than a fixed digit limit.
    assign at_max = (live_m_tens == MAX_M_TENS) && (live_m_ones == MAX_M_ONES);
    assign wrap   = min_inc && at_max;

    always_ff @(posedge clk_in) begin
        if (rst || clr_count) begin
            live_m_tens <= '0;
            live_m_ones <= '0;
        end else if (min_inc) begin
            if (at_max) begin
                live_m_tens <= '0;
                live_m_ones <= '0;
            end else if (live_m_ones == LIMIT_NINE) begin
                live_m_ones <= '0;
                live_m_tens <= live_m_tens + 4'd1;
            end else begin
                live_m_ones <= live_m_ones + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst || clr_count) begin
            overflow <= 1'b0;
        end else if (wrap) begin
            overflow <= 1'b1;
        end
    end

`ifdef LAP_HOLD_EN
    logic                   hold_active;
    logic [6*DIGIT_W-1:0]   hold_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            hold_active <= 1'b0;
            hold_q      <= '0;
        end else if (clear || state_next == IDLE) begin
            hold_active <= 1'b0;
        end else if (lap && state == RUN) begin
            hold_active <= !hold_active;
            if (!hold_active) begin
                hold_q <= {live_m_tens, live_m_ones, live_s_tens, live_s_ones,
                           live_cs_tens, live_cs_ones};
            end
        end
    end

    assign {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones} = hold_active ? hold_q :
           {live_m_tens, live_m_ones, live_s_tens, live_s_ones, live_cs_tens, live_cs_ones};
`else
    assign {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones} =
           {live_m_tens, live_m_ones, live_s_tens, live_s_ones, live_cs_tens, live_cs_ones};
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter (built with MAX_MINUTES = 1 so the
// wrap is reachable): control table, carry/wrap sequences, random vs. model.
module tb_stopwatch_counter;

    localparam int MAXM = 1;
    localparam int WRAP = (MAXM + 1) * 6000;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       clk_100hz_in = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] cs_tens, cs_ones, s_tens, s_ones, m_tens, m_ones;
    logic       running, overflow;
`ifdef LAP_HOLD_EN
    logic       lap = 1'b0;
    bit         lap_drv = 1'b0;
`endif

    stopwatch_counter #(.MAX_MINUTES(MAXM)) dut (
        .clk_in(clk_in),
        .rst(rst),
        .clk_100hz_in(clk_100hz_in),
        .start_stop(start_stop),
        .clear(clear),
`ifdef LAP_HOLD_EN
        .lap(lap),
`endif
        .cs_tens(cs_tens),
        .cs_ones(cs_ones),
        .s_tens(s_tens),
        .s_ones(s_ones),
        .m_tens(m_tens),
        .m_ones(m_ones),
        .running(running),
        .overflow(overflow)
    );

    always #10 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    // Reference model: elapsed time as a plain centisecond total.
    int m_cnt   = 0;
    bit m_prev  = 0;
    bit m_ovf   = 0;
    int m_mode  = 0; // 0 idle, 1 run, 2 pause

    function automatic void model_step(bit r, bit ss, bit cl, bit ck);
        bit t;
        t = ck && !m_prev;
        if (r) begin
            m_prev = 0; m_cnt = 0; m_ovf = 0; m_mode = 0;
            return;
        end
        m_prev = ck;
        if (m_mode == 1 && t) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == WRAP) begin
                m_cnt = 0;
                m_ovf = 1;
            end
        end
        if (m_mode == 0) begin
            if (cl) m_ovf = 0;
            else if (ss) m_mode = 1;
        end else if (m_mode == 1) begin
            if (ss) m_mode = 2;
        end else begin
            if (cl) begin
                m_cnt = 0; m_ovf = 0; m_mode = 0;
            end else if (ss) m_mode = 1;
        end
    endfunction

    function automatic logic [23:0] bcd_of(int c);
        int cs, s, m;
        cs = c % 100;
        s  = (c / 100) % 60;
        m  = c / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic cycle(input bit r, input bit ss, input bit cl, input bit ck);
        @(negedge clk_in);
        rst = r; start_stop = ss; clear = cl; clk_100hz_in = ck;
`ifdef LAP_HOLD_EN
        lap = lap_drv;
`endif
        @(posedge clk_in);
        model_step(r, ss, cl, ck);
        #1;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 0, 0, 1);
            cycle(0, 0, 0, 0);
        end
    endtask

    task automatic check(input string name, input int exp_cnt, input bit exp_run, input bit exp_ovf);
        logic [23:0] got;
        got = {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones};
        tests++;
        if (got !== bcd_of(exp_cnt) || running !== exp_run || overflow !== exp_ovf) begin
            fails++;
            $display("FAIL %s: got digits=%h running=%b overflow=%b, expected digits=%h running=%b overflow=%b",
                     name, got, running, overflow, bcd_of(exp_cnt), exp_run, exp_ovf);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_cnt, m_mode == 1, m_ovf);
    endtask

    typedef struct {
        bit ss;
        bit cl;
        bit ck;
        bit run;
        int cnt;
        bit ovf;
    } vec_t;

    vec_t tbl[18];

    initial begin
        bit ck_lvl;
        bit r, ss, cl;

        tbl[0]  = '{0, 0, 1, 0, 0, 0};  // tick in IDLE ignored
        tbl[1]  = '{0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 1, 1, 0, 0};  // start with tick: not counted
        tbl[5]  = '{0, 0, 0, 1, 0, 0};
        tbl[6]  = '{0, 0, 1, 1, 1, 0};
        tbl[7]  = '{0, 0, 1, 1, 1, 0};  // level held: no second tick
        tbl[8]  = '{0, 1, 0, 1, 1, 0};  // clear in RUN ignored
        tbl[9]  = '{0, 0, 0, 1, 1, 0};
        tbl[10] = '{1, 0, 1, 0, 2, 0};  // stop with tick: counted
        tbl[11] = '{0, 0, 0, 0, 2, 0};
        tbl[12] = '{0, 0, 1, 0, 2, 0};  // tick in PAUSE ignored
        tbl[13] = '{0, 0, 0, 0, 2, 0};
        tbl[14] = '{1, 1, 0, 0, 0, 0};  // both in PAUSE: clear wins
        tbl[15] = '{1, 1, 0, 0, 0, 0};  // both in IDLE: clear wins
        tbl[16] = '{1, 0, 0, 1, 0, 0};
        tbl[17] = '{1, 1, 1, 0, 1, 0};  // both in RUN: stop wins, tick counted

        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("reset", 0, 0, 0);

        foreach (tbl[i]) begin
            cycle(0, tbl[i].ss, tbl[i].cl, tbl[i].ck);
            check($sformatf("table[%0d]", i), tbl[i].cnt, tbl[i].run, tbl[i].ovf);
        end

        // Long high level on the divider output counts once.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        check("tick_latency", 1, 1, 0);
        for (int i = 0; i < 999; i++) cycle(0, 0, 0, 1);
        check("held_high", 1, 1, 0);
        cycle(0, 0, 0, 0);

        // Pause at 00:05.00 then start_stop + clear together.
        do_ticks(499);
        check("at_0500", 500, 1, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 0);
        check("pause_both_idle", 0, 0, 0);

        // Carry chain and wrap at MAX_MINUTES:59.99.
        cycle(0, 1, 0, 0);
        do_ticks(99);
        check("to_0099", 99, 1, 0);
        do_ticks(1);
        check("cs_carry", 100, 1, 0);
        do_ticks(5899);
        check("to_5999", 5999, 1, 0);
        do_ticks(1);
        check("min_carry", 6000, 1, 0);
        do_ticks(5999);
        check("at_max", WRAP - 1, 1, 0);
        do_ticks(1);
        check("wrap", 0, 1, 1);
        do_ticks(3);
        check("after_wrap", 3, 1, 1);
        cycle(0, 1, 0, 0);
        check("pause_keeps_ovf", 3, 0, 1);
        cycle(0, 0, 1, 0);
        check("clear_ovf", 0, 0, 0);

`ifdef LAP_HOLD_EN
        cycle(0, 1, 0, 0);
        do_ticks(250);
        lap_drv = 1;
        cycle(0, 0, 0, 0);
        lap_drv = 0;
        do_ticks(30);
        check("lap_frozen", 250, 1, 0);
        lap_drv = 1;
        cycle(0, 0, 0, 0);
        lap_drv = 0;
        check("lap_release", 280, 1, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);
`endif

        // Random traffic against the reference model.
        ck_lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 499) == 0);
            ss = ($urandom_range(0, 15) == 0);
            cl = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0) ck_lvl = !ck_lvl;
            cycle(r, ss, cl, ck_lvl);
            check_model("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
